// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, frame width and chip-select helper.
package spi_pkg;

  localparam int SPI_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } spi_state_e;

  // Active-low chip-select level for line idx when slave sel is addressed.
  function automatic logic cs_level(input logic [2:0] sel, input int idx);
    return !(int'(sel) == idx);
  endfunction

endpackage

// File: rtl/spi_clk_divider.sv
// Phase counter for SCLK timing: phase_end pulses on the last clk cycle of every
// CLK_DIV-cycle phase; clear restarts the phase so a new transfer begins aligned.
module spi_clk_divider
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic phase_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign phase_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || phase_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: one 8-bit LSB-first full-duplex transfer per accepted start, SCLK
// idles low, MOSI changes with SCLK rise, MISO sampled on the last cycle of SCLK high.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            slaveSelect,
  input  logic [SPI_BITS-1:0]   masterDataToSend,
  output logic [SPI_BITS-1:0]   masterDataReceived,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] CS,
  output logic                  MOSI,
  input  logic                  MISO,
  output spi_state_e            dbg_state
);

  spi_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SPI_BITS-1:0]   tx_q, tx_d;
  logic [SPI_BITS-1:0]   rx_q, rx_d;
  logic [SPI_BITS-1:0]   rx_out_q, rx_out_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  div_clear;
  logic                  phase_end;

  spi_clk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .clear     (div_clear),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_out_d  = rx_out_q;
    bit_cnt_d = bit_cnt_q;
    div_clear = 1'b0;

    case (state_q)
      IDLE: begin
        // Out-of-range selects are dropped silently so no bus activity occurs.
        if (start && (int'(slaveSelect) < NUM_SLAVES)) begin
          for (int i = 0; i < NUM_SLAVES; i++) begin
            cs_d[i] = cs_level(slaveSelect, i);
          end
          tx_d      = masterDataToSend;
          mosi_d    = masterDataToSend[0];
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          div_clear = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          mosi_d  = tx_q[bit_cnt_q[2:0]];
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          rx_d    = {MISO, rx_q[SPI_BITS-1:1]};
          sclk_d  = 1'b0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (phase_end) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(SPI_BITS - 1)) begin
            state_d = HOLD;
          end else begin
            sclk_d  = 1'b1;
            mosi_d  = tx_q[bit_cnt_q[2:0] + 3'd1];
            state_d = HIGH;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          cs_d     = '1;
          mosi_d   = 1'b0;
          rx_out_d = rx_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        cs_d    = '1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cs_q      <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_out_q  <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_out_q  <= rx_out_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign masterDataReceived = rx_out_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign SCLK               = sclk_q;
  assign CS                 = cs_q;
  assign MOSI               = mosi_q;
  assign dbg_state          = state_q;

endmodule
